// File: rtl/da_pkg.sv
// Shared constants, FSM states and coefficient array types for the DA LUT loader.
// Defining DA_LUT_SYMMETRIC_EN stores only half the coefficients and mirrors them.
package da_pkg;

  localparam int DA_COEF_W  = 16;
  localparam int DA_LUT_W   = 20;
  localparam int DA_NBANK   = 8;
  localparam int DA_TAPS    = 8;
  localparam int DA_CADDR_W = 11;
  localparam int DA_NCOEF   = 64;

`ifdef DA_LUT_SYMMETRIC_EN
  localparam int DA_NSTORE = DA_NCOEF / 2;
`else
  localparam int DA_NSTORE = DA_NCOEF;
`endif

  typedef enum logic [1:0] {
    COLLECT,
    GEN,
    DONE
  } da_state_t;

  typedef logic [DA_TAPS-1:0][DA_COEF_W-1:0]  coef_bank_t;
  typedef logic [DA_NCOEF-1:0][DA_COEF_W-1:0] coef_arr_t;

endpackage

// File: rtl/da_lut_adder.sv
// Combinational masked sum of one bank's eight coefficients, producing one
// sign-extended DA partial-sum LUT entry.
module da_lut_adder
  import da_pkg::*;
(
  input  logic [DA_TAPS-1:0][DA_COEF_W-1:0] coef,
  input  logic [DA_TAPS-1:0]                mask,
  output logic [DA_LUT_W-1:0]               sum
);

  always_comb begin
    sum = '0;
    for (int k = 0; k < DA_TAPS; k++) begin
      if (mask[k]) begin
        sum = sum + {{(DA_LUT_W-DA_COEF_W){coef[k][DA_COEF_W-1]}}, coef[k]};
      end
    end
  end

endmodule

// File: rtl/da_lut_loader.sv
// Collects FIR coefficients, then streams all 2048 DA LUT entries to the SRAM.
// Optional macro DA_LUT_SYMMETRIC_EN: accept 32 coefficients, mirror coef[63-i]=coef[i].
module da_lut_loader
  import da_pkg::*;
#(
  parameter int COEF_W        = 16,
  parameter int LUT_W         = 20,
  parameter int NBANK         = 8,
  parameter int TAPS_PER_BANK = 8
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [COEF_W-1:0]                         coef_in,
  input  logic                                      coef_valid,
  output logic                                      coef_ready,
  output logic [LUT_W-1:0]                          CIN,
  output logic [$clog2(NBANK)+TAPS_PER_BANK-1:0]    CADDR,
  output logic                                      CLOAD,
  output logic                                      busy,
  output logic                                      done
);

  localparam int IDX_W = $clog2(DA_NSTORE);

  da_state_t                            state, state_next;
  logic [DA_NSTORE-1:0][DA_COEF_W-1:0]  coef_q;
  coef_arr_t                            coef_full;
  coef_bank_t                           bank_sel;
  logic [IDX_W-1:0]                     idx;
  logic                                 ready_q, busy_q, done_q, load_q;
  logic [DA_CADDR_W-1:0]                addr_q;
  logic [DA_LUT_W-1:0]                  cin_q;

  logic                                 handshake, last_hs;
  logic                                 load_d, busy_d, done_d;
  logic [DA_CADDR_W-1:0]                addr_d;
  logic [DA_LUT_W-1:0]                  entry, cin_d;

  assign handshake = coef_valid & ready_q & (state == COLLECT);
  assign last_hs   = handshake & (idx == IDX_W'(DA_NSTORE - 1));

`ifdef DA_LUT_SYMMETRIC_EN
  // Upper half of the tap vector is the mirror image of the stored half
  always_comb begin
    for (int j = 0; j < DA_NCOEF; j++) begin
      coef_full[j] = coef_q[IDX_W'((j < DA_NSTORE) ? j : (DA_NCOEF - 1 - j))];
    end
  end
`else
  assign coef_full = coef_q;
`endif

  always_comb begin
    bank_sel = '0;
    for (int k = 0; k < DA_TAPS; k++) begin
      bank_sel[k] = coef_full[{addr_d[DA_CADDR_W-1:DA_TAPS], 3'(k)}];
    end
  end

  da_lut_adder u_adder (
    .coef (bank_sel),
    .mask (addr_d[DA_TAPS-1:0]),
    .sum  (entry)
  );

  // addr_q doubles as the GEN counter; outputs are computed one cycle ahead
  always_comb begin
    state_next = state;
    load_d     = 1'b0;
    addr_d     = '0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state)
      COLLECT: begin
        if (handshake) busy_d = 1'b1;
        if (last_hs) begin
          state_next = GEN;
          load_d     = 1'b1;
        end
      end
      GEN: begin
        if (addr_q == {DA_CADDR_W{1'b1}}) begin
          state_next = DONE;
          done_d     = 1'b1;
          busy_d     = 1'b0;
        end else begin
          load_d = 1'b1;
          addr_d = addr_q + 1'b1;
        end
      end
      DONE: begin
        state_next = COLLECT;
        busy_d     = 1'b0;
      end
      default: state_next = COLLECT;
    endcase
    cin_d = load_d ? entry : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= COLLECT;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      load_q  <= 1'b0;
      addr_q  <= '0;
      cin_q   <= '0;
      idx     <= '0;
    end else begin
      state   <= state_next;
      ready_q <= (state_next == COLLECT);
      busy_q  <= busy_d;
      done_q  <= done_d;
      load_q  <= load_d;
      addr_q  <= addr_d;
      cin_q   <= cin_d;
      if (last_hs)        idx <= '0;
      else if (handshake) idx <= idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coef_q <= '0;
    end else if (handshake) begin
      coef_q[idx] <= coef_in;
    end
  end

  assign coef_ready = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign CLOAD      = load_q;
  assign CADDR      = addr_q;
  assign CIN        = cin_q;

endmodule

// File: tb/tb_da_lut_loader.sv
// Directed bench for da_lut_loader: coefficient capture, LUT streaming,
// done timing, reset during GEN and reload behaviour.
module tb_da_lut_loader;

`ifdef DA_LUT_SYMMETRIC_EN
  localparam int NLOAD = 32;
`else
  localparam int NLOAD = 64;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] coef_in = '0;
  logic        coef_valid = 1'b0;
  logic        coef_ready;
  logic [19:0] CIN;
  logic [10:0] CADDR;
  logic        CLOAD, busy, done;

  int errors = 0;
  int checks = 0;

  logic signed [15:0] mc [64];
  logic [19:0]        lut [2048];
  int                 rdy_cnt;
  int                 hs_cnt;

  always #5 clk = ~clk;

  da_lut_loader dut (
    .clk        (clk),
    .reset      (reset),
    .coef_in    (coef_in),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .CIN        (CIN),
    .CADDR      (CADDR),
    .CLOAD      (CLOAD),
    .busy       (busy),
    .done       (done)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] coef_val(input int pattern, input int i);
    case (pattern)
      0:       return 16'd1;
      1:       return 16'(i);
      2:       return 16'h8000;
      3:       return 16'($urandom);
      default: return 16'(i * 37 - 1000);
    endcase
  endfunction

  function automatic logic [19:0] exp_entry(input int n);
    int acc = 0;
    int b = n / 256;
    int a = n % 256;
    for (int k = 0; k < 8; k++) begin
      if (((a >> k) & 1) == 1) acc = acc + int'(mc[b*8+k]);
    end
    return 20'(acc);
  endfunction

  // Drives one full coefficient set; called and returns #1 after a clock edge
  task automatic apply_stimulus(input int pattern, input bit toggle);
    int  cyc = 0;
    bit  will;
    hs_cnt  = 0;
    rdy_cnt = 0;
    while (hs_cnt < NLOAD && cyc < 400) begin
      if (coef_ready) rdy_cnt++;
      coef_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      coef_in    = coef_val(pattern, hs_cnt);
      will       = coef_valid && coef_ready;
      @(posedge clk); #1;
      if (will) begin
        mc[hs_cnt] = coef_in;
`ifdef DA_LUT_SYMMETRIC_EN
        mc[63-hs_cnt] = coef_in;
`endif
        hs_cnt++;
      end
      cyc++;
    end
    coef_valid = 1'b0;
    check_output("load_handshakes", 32'(hs_cnt), 32'(NLOAD));
  endtask

  // Records the GEN stream starting in the first GEN cycle; checks framing and LUT
  task automatic capture(input string pfx, input bit hold_valid);
    int cnt = 0, gaps = 0, done_cnt = 0, done_cyc = -1;
    int ready_gen = 0, busy_low = 0, bad = 0, c;
    logic first_load;
    logic [31:0] done_out = 32'hFFFF_FFFF;
    first_load = CLOAD;
    if (hold_valid) begin
      coef_valid = 1'b1;
      coef_in    = 16'h7777;
    end
    for (c = 0; c < 2100; c++) begin
      if (done_cyc >= 0 && c == done_cyc + 1) break;
      if (CLOAD) begin
        if (CADDR !== 11'(cnt)) gaps++;
        lut[CADDR] = CIN;
        cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc   = c;
        done_out   = {9'b0, CLOAD, busy, CADDR, CIN[9:0]} | (CIN[19:10] != 0 ? 32'h8000_0000 : 32'h0);
        coef_valid = 1'b0;
      end else begin
        if (coef_ready) ready_gen++;
        if (!busy) busy_low++;
      end
      @(posedge clk); #1;
    end
    check_output({pfx, "_first_cload"}, 32'(first_load), 32'd1);
    check_output({pfx, "_cload_count"}, 32'(cnt), 32'd2048);
    check_output({pfx, "_addr_gaps"}, 32'(gaps), 32'd0);
    check_output({pfx, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check_output({pfx, "_done_cycle"}, 32'(done_cyc), 32'd2048);
    check_output({pfx, "_done_outputs"}, done_out, 32'd0);
    check_output({pfx, "_ready_in_gen"}, 32'(ready_gen), 32'd0);
    check_output({pfx, "_busy_low_in_gen"}, 32'(busy_low), 32'd0);
    check_output({pfx, "_ready_after_done"}, 32'(coef_ready), 32'd1);
    for (int n = 0; n < 2048; n++) begin
      if (lut[n] !== exp_entry(n)) bad++;
    end
    check_output({pfx, "_lut_full"}, 32'(bad), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_CIN", 32'(CIN), 32'd0);
    check_output("rst_CADDR", 32'(CADDR), 32'd0);
    check_output("rst_CLOAD", 32'(CLOAD), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_ready", 32'(coef_ready), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_output("ready_after_reset", 32'(coef_ready), 32'd1);
    check_output("busy_idle", 32'(busy), 32'd0);

    // Test 1: all ones, continuous valid
    apply_stimulus(0, 1'b0);
    check_output("t1_ready_cycles", 32'(rdy_cnt), 32'(NLOAD));
    check_output("t1_ready_low_gen", 32'(coef_ready), 32'd0);
    capture("t1", 1'b0);
    check_output("t1_lut_0ff", 32'(lut[11'h0FF]), 32'd8);
    check_output("t1_lut_501", 32'(lut[11'h501]), 32'd1);
    check_output("t1_lut_000", 32'(lut[11'h000]), 32'd0);

    // Test 2 and 5: ramp with toggling valid, valid held high through GEN
    apply_stimulus(1, 1'b1);
    capture("t2", 1'b1);
`ifndef DA_LUT_SYMMETRIC_EN
    check_output("t2_lut_3ff", 32'(lut[11'h3FF]), 32'd220);
    check_output("t2_lut_081", 32'(lut[11'h081]), 32'd7);
`else
    check_output("t6_lut_780", 32'(lut[11'h780]), 32'd0);
    check_output("t6_lut_701", 32'(lut[11'h701]), 32'd7);
`endif

    // Test 3: most negative coefficient everywhere
    apply_stimulus(2, 1'b0);
    capture("t3", 1'b0);
    check_output("t3_lut_7ff", 32'(lut[11'h7FF]), 32'h000C_0000);

    // Test 4: reset at GEN cycle 1000, then a full reload
    apply_stimulus(3, 1'b0);
    repeat (1000) @(posedge clk);
    #1;
    check_output("t4_cload_before_rst", 32'(CLOAD), 32'd1);
    check_output("t4_caddr_before_rst", 32'(CADDR), 32'd1000);
    reset = 1'b1;
    #1;
    check_output("t4_cload_async", 32'(CLOAD), 32'd0);
    check_output("t4_busy_async", 32'(busy), 32'd0);
    check_output("t4_caddr_async", 32'(CADDR), 32'd0);
    @(posedge clk); #1;
    check_output("t4_cload_held", 32'(CLOAD), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_output("t4_ready_after_rst", 32'(coef_ready), 32'd1);
    apply_stimulus(4, 1'b0);
    capture("t4", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/da_lut_loader.md
Name: da_lut_loader

Overview:
- Coefficient-side writer for the distributed-arithmetic FIR ROM bank.
- Accepts FIR tap coefficients over a valid/ready stream and precomputes every DA partial-sum LUT entry.
- Streams the entries into the 8-bank LUT SRAM through the CIN/CADDR/CLOAD write port, then pulses done.
- The DA datapath start is held off while busy is high.

Parameters:
- COEF_W, 16, signed coefficient width.
- LUT_W, 20, LUT entry width; equals the SRAM D width.
- NBANK, 8, number of LUT banks; one bank per DA address byte.
- TAPS_PER_BANK, 8, coefficients per bank; equals the bank address width.
- Only the defaults are supported with the DA datapath. CADDR is 3+8=11 bits.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- coef_in  in  16  signed coefficient; index order 0..63.
- coef_valid  in  1  coef_in is valid.
- coef_ready  out  1  block accepts a coefficient this cycle.
- CIN  out  20  LUT entry write data.
- CADDR  out  11  {bank[2:0], addr[7:0]}.
- CLOAD  out  1  write strobe; one LUT entry per cycle while high.
- busy  out  1  high from the first accepted coefficient until done.
- done  out  1  one-cycle pulse after the last entry is written.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-high (reset).
  - Asserting reset immediately forces state=COLLECT, coefficient index=0, and all stored coefficients=0.
  - Outputs during reset: CIN=0, CADDR=0, CLOAD=0, busy=0, done=0, coef_ready=0.
  - coef_ready=1 from the first clock edge after reset deasserts.
- State machine: COLLECT -> GEN -> DONE -> COLLECT.
- COLLECT:
  - coef_ready=1.
  - A handshake occurs when coef_valid & coef_ready. It stores coef_in at coef[idx] and increments idx.
  - busy goes high on the first handshake.
  - The handshake at idx=63 moves the state to GEN and clears the address counter.
- GEN:
  - coef_ready=0; coef_valid is ignored.
  - The 11-bit counter n runs 0..2047, one step per cycle.
  - Outputs are registered, one cycle latency from n: CLOAD=1, CADDR=n, CIN=entry(n).
  - The first CLOAD=1 cycle is the cycle after the idx-63 handshake.
  - Exactly 2048 consecutive CLOAD cycles, with no gaps.
- Entry arithmetic:
  - b=n[10:8], a=n[7:0].
  - entry = sum over k=0..7 with a[k]=1 of sign-extended coef[b*8+k].
  - The result fits in 19 bits signed and is sign-extended to 20. It never overflows, so there is no saturation.
  - entry(a=0)=0.
- DONE:
  - Entered after the n=2047 write cycle.
  - That cycle: CLOAD=0, CIN=0, CADDR=0, done=1, busy=0.
  - Next cycle: state=COLLECT and idx=0.
- Reloading: a new set of 64 coefficients fully overwrites the previous set and rewrites the whole LUT.
- Reset during GEN: CLOAD drops asynchronously and no further writes occur. The SRAM contents are then undefined, and the DA must not start until the next done.
- In COLLECT, coef_ready is never low, so the coefficient source is never back-pressured.

Optional Feature:
- Macro DA_LUT_SYMMETRIC_EN, for symmetric linear-phase FIRs.
- Defined:
  - Only 32 coefficients are accepted; the idx-31 handshake enters GEN.
  - coef[63-i] is taken equal to coef[i], so only 32 coefficient registers exist.
  - GEN output is otherwise identical.
- Undefined: 64 coefficients are required, as described above.

Decomposition:
- Package da_pkg holds:
  - constants DA_COEF_W=16, DA_LUT_W=20, DA_NBANK=8, DA_TAPS=8, DA_CADDR_W=11, DA_NCOEF=64;
  - the state enum {COLLECT, GEN, DONE};
  - a coefficient-array typedef.
- Sub-module da_lut_adder is combinational:
  - inputs: eight 16-bit signed coefficients and an 8-bit mask;
  - output: the 20-bit sign-extended masked sum.
- The top level holds the FSM, coefficient storage, counters and output registers.

Test Plan:
1. coef[i]=1 for all i, valid continuous -> coef_ready high 64 cycles; then 2048 CLOAD cycles; CIN at CADDR=0x0FF is 8, at 0x501 is 1, at 0x000 is 0; done pulses once, exactly 1 cycle after the CLOAD at 0x7FF.
2. coef[i]=i, valid toggling every other cycle -> capture is correct; CIN@CADDR=0x3FF = 24+...+31 = 220, CIN@0x081 = 0+7 = 7.
3. coef[i]=-32768 for all i -> CIN@0x7FF = -262144 = 0xC0000 (20-bit), with no overflow.
4. Reset asserted at GEN cycle 1000 -> CLOAD=0 in the same cycle (async) and busy=0; a full reload afterwards produces a correct LUT.
5. coef_valid held high during GEN -> no additional coefficient is captured; the second load after done starts at idx 0.
6. With DA_LUT_SYMMETRIC_EN, coef[i]=i for i<32 -> GEN starts after 32 handshakes; CIN@0x780 = coef[63] = 0, CIN@0x701 = coef[56] = 7.
